// File: rtl/bcd_seq_alu.sv
// Sequential BCD ALU: packed-BCD operands are decoded to binary, then run
// through a single-cycle add/sub or a multi-cycle mul/div/mod/pow engine.
module bcd_seq_alu #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned OUT_W  = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic [2:0]          op,
  output logic                busy,
  output logic                done,
  output logic [OUT_W-1:0]    out,
  output logic                ovf,
  output logic                neg,
  output logic                dz,
  output logic                err
);

  localparam int unsigned OPW = 4 * DIGITS;
  // Wide enough for acc*num1 in pow and the full mul product.
  localparam int unsigned EW  = OUT_W + OPW + 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_POW = 3'd4;
  localparam logic [2:0] OP_MOD = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [OPW-1:0]   r_a, w_a_nxt;
  logic [OPW-1:0]   r_b, w_b_nxt;
  logic [2:0]       r_op, w_op_nxt;
  logic [OPW-1:0]   r_n1, w_n1_nxt;
  logic [OPW-1:0]   r_n2, w_n2_nxt;
  logic [OPW-1:0]   r_hi, w_hi_nxt;
  logic [OPW-1:0]   r_lo, w_lo_nxt;
  logic [OPW-1:0]   r_cnt, w_cnt_nxt;
  logic [OUT_W-1:0] r_pacc, w_pacc_nxt;
  logic             r_povf, w_povf_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [OUT_W-1:0] r_out, w_out_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_neg, w_neg_nxt;
  logic             r_dz, w_dz_nxt;
  logic             r_err, w_err_nxt;

  function automatic logic [OPW-1:0] bcd2bin(input logic [OPW-1:0] v);
    logic [OPW+3:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      acc = (acc << 3) + (acc << 1) + (OPW+4)'(v[4*(DIGITS-1-i) +: 4]);
    end
    return acc[OPW-1:0];
  endfunction

  function automatic logic bad_digit(input logic [OPW-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  logic [OPW-1:0] w_n1, w_n2;
  logic           w_bad;
  logic [EW-1:0]  w_asum;
  logic [OPW:0]   w_msum;
  logic [OPW-1:0] w_mhi, w_mlo;
  logic [EW-1:0]  w_mprod;
  logic [OPW:0]   w_rsh;
  logic [OPW-1:0] w_rdiff;
  logic           w_dge;
  logic [OPW-1:0] w_dhi, w_dlo;
  logic [EW-1:0]  w_pprod;
  logic           w_povf_step;

  assign w_n1  = bcd2bin(r_a);
  assign w_n2  = bcd2bin(r_b);
  assign w_bad = bad_digit(r_a) | bad_digit(r_b) | (r_op > OP_MOD);

  assign w_asum = EW'(r_n1) + EW'(r_n2);

  // Shift-add step: {hi,lo} holds partial product and remaining multiplier bits.
  assign w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_n1} : '0);
  assign w_mhi   = w_msum[OPW:1];
  assign w_mlo   = {w_msum[0], r_lo[OPW-1:1]};
  assign w_mprod = EW'({w_mhi, w_mlo});

  // Restoring division step: hi is the remainder, lo shifts dividend out / quotient in.
  assign w_rsh   = {r_hi, r_lo[OPW-1]};
  assign w_dge   = (w_rsh >= {1'b0, r_n2});
  assign w_rdiff = w_rsh[OPW-1:0] - r_n2;
  assign w_dhi   = w_dge ? w_rdiff : w_rsh[OPW-1:0];
  assign w_dlo   = {r_lo[OPW-2:0], w_dge};

  assign w_pprod     = EW'(r_pacc) * EW'(r_n1);
  assign w_povf_step = |w_pprod[EW-1:OUT_W];

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    w_n1_nxt    = r_n1;
    w_n2_nxt    = r_n2;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_cnt_nxt   = r_cnt;
    w_pacc_nxt  = r_pacc;
    w_povf_nxt  = r_povf;
    w_done_nxt  = 1'b0;
    w_out_nxt   = r_out;
    w_ovf_nxt   = r_ovf;
    w_neg_nxt   = r_neg;
    w_dz_nxt    = r_dz;
    w_err_nxt   = r_err;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_a_nxt     = a;
          w_b_nxt     = b;
          w_op_nxt    = op;
          w_state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        w_n1_nxt = w_n1;
        w_n2_nxt = w_n2;
        if (w_bad) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_out_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_neg_nxt   = 1'b0;
          w_dz_nxt    = 1'b0;
          w_err_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_EXEC;
          w_hi_nxt    = '0;
          w_lo_nxt    = (r_op == OP_DIV || r_op == OP_MOD) ? w_n1 : w_n2;
          w_pacc_nxt  = OUT_W'(1);
          w_povf_nxt  = 1'b0;
          case (r_op)
            OP_MUL, OP_DIV, OP_MOD: w_cnt_nxt = OPW'(OPW);
            OP_POW:                 w_cnt_nxt = (w_n2 == '0) ? OPW'(1) : w_n2;
            default:                w_cnt_nxt = OPW'(1);
          endcase
        end
      end

      S_EXEC: begin
        w_cnt_nxt = r_cnt - OPW'(1);
        case (r_op)
          OP_MUL: begin
            w_hi_nxt = w_mhi;
            w_lo_nxt = w_mlo;
          end
          OP_DIV, OP_MOD: begin
            w_hi_nxt = w_dhi;
            w_lo_nxt = w_dlo;
          end
          OP_POW: begin
            w_pacc_nxt = w_pprod[OUT_W-1:0];
            w_povf_nxt = r_povf | w_povf_step;
          end
          default: ;
        endcase

        if (r_cnt == OPW'(1)) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_ovf_nxt   = 1'b0;
          w_neg_nxt   = 1'b0;
          w_dz_nxt    = 1'b0;
          w_err_nxt   = 1'b0;
          case (r_op)
            OP_ADD: begin
              w_out_nxt = w_asum[OUT_W-1:0];
              w_ovf_nxt = |w_asum[EW-1:OUT_W];
            end
            OP_SUB: begin
              w_out_nxt = OUT_W'(r_n1) - OUT_W'(r_n2);
              w_neg_nxt = (r_n2 > r_n1);
            end
            OP_MUL: begin
              w_out_nxt = w_mprod[OUT_W-1:0];
              w_ovf_nxt = |w_mprod[EW-1:OUT_W];
            end
            OP_DIV, OP_MOD: begin
              if (r_n2 == '0) begin
                w_out_nxt = '1;
                w_dz_nxt  = 1'b1;
                w_err_nxt = 1'b1;
              end else if (r_op == OP_DIV) begin
                w_out_nxt = OUT_W'(w_dlo);
              end else begin
                w_out_nxt = OUT_W'(w_dhi);
              end
            end
            OP_POW: begin
              if (r_n2 == '0) begin
                w_out_nxt = OUT_W'(1);
              end else begin
                w_out_nxt = w_pprod[OUT_W-1:0];
                w_ovf_nxt = r_povf | w_povf_step;
              end
            end
            default: w_out_nxt = '0;
          endcase
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_n1    <= '0;
      r_n2    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_pacc  <= '0;
      r_povf  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      r_neg   <= 1'b0;
      r_dz    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
      r_n1    <= w_n1_nxt;
      r_n2    <= w_n2_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pacc  <= w_pacc_nxt;
      r_povf  <= w_povf_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_out   <= w_out_nxt;
      r_ovf   <= w_ovf_nxt;
      r_neg   <= w_neg_nxt;
      r_dz    <= w_dz_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign out  = r_out;
  assign ovf  = r_ovf;
  assign neg  = r_neg;
  assign dz   = r_dz;
  assign err  = r_err;

endmodule

// File: tb/tb_bcd_seq_alu.sv
// Bench for bcd_seq_alu (DIGITS=2, OUT_W=14): directed cases, reset abort,
// and random operations checked against an arithmetic reference model.
module tb_bcd_seq_alu;

  localparam int    OUT_W  = 14;
  localparam int    OPW    = 8;
  localparam longint MODV  = 64'd1 << OUT_W;
  localparam int    BUDGET = 200;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [7:0]       a, b;
  logic [2:0]       op;
  logic             busy, done, ovf, neg, dz, err;
  logic [OUT_W-1:0] out;

  int errors = 0;
  int checks = 0;
  int o_lat;
  logic [OUT_W-1:0] o_out;
  logic o_ovf, o_neg, o_dz, o_err, o_busy;

  bcd_seq_alu #(.DIGITS(2), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .out(out), .ovf(ovf), .neg(neg), .dz(dz), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive a request and return #1 after the accepting edge.
  task automatic launch(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop);
    a = ia; b = ib; op = iop; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
  endtask

  // Count edges from acceptance until done, then capture the result.
  task automatic wait_done(input int elapsed);
    o_lat = 0;
    for (int k = elapsed + 1; k <= BUDGET; k++) begin
      @(posedge clk); #1;
      if (done) begin
        o_lat = k;
        break;
      end
    end
    chk("done_within_budget", 64'(o_lat != 0), 64'd1);
    o_out = out; o_ovf = ovf; o_neg = neg; o_dz = dz; o_err = err; o_busy = busy;
  endtask

  task automatic chk_res(input string tag, input longint e_out, input longint e_ovf,
                         input longint e_neg, input longint e_dz, input longint e_err,
                         input longint e_lat);
    chk({tag, ".lat"},  64'(o_lat), 64'(e_lat));
    chk({tag, ".out"},  64'(o_out), 64'(e_out));
    chk({tag, ".ovf"},  64'(o_ovf), 64'(e_ovf));
    chk({tag, ".neg"},  64'(o_neg), 64'(e_neg));
    chk({tag, ".dz"},   64'(o_dz),  64'(e_dz));
    chk({tag, ".err"},  64'(o_err), 64'(e_err));
    chk({tag, ".busy"}, 64'(o_busy), 64'd0);
  endtask

  function automatic longint bcd_val(input logic [7:0] v);
    return longint'(v[7:4]) * 10 + longint'(v[3:0]);
  endfunction

  task automatic model(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop,
                       output longint e_out, output longint e_ovf, output longint e_neg,
                       output longint e_dz, output longint e_err, output longint e_lat);
    longint n1, n2, p, acc;
    e_out = 0; e_ovf = 0; e_neg = 0; e_dz = 0; e_err = 0;
    if (ia[7:4] > 9 || ia[3:0] > 9 || ib[7:4] > 9 || ib[3:0] > 9 || iop > 5) begin
      e_err = 1; e_lat = 1;
      return;
    end
    n1 = bcd_val(ia);
    n2 = bcd_val(ib);
    case (iop)
      3'd0: begin p = n1 + n2; e_out = p % MODV; e_ovf = longint'(p >= MODV); e_lat = 2; end
      3'd1: begin e_out = (n1 - n2 + MODV) % MODV; e_neg = longint'(n2 > n1); e_lat = 2; end
      3'd2: begin p = n1 * n2; e_out = p % MODV; e_ovf = longint'(p >= MODV); e_lat = 1 + OPW; end
      3'd3, 3'd5: begin
        e_lat = 1 + OPW;
        if (n2 == 0) begin e_out = MODV - 1; e_dz = 1; e_err = 1; end
        else e_out = (iop == 3'd3) ? n1 / n2 : n1 % n2;
      end
      default: begin
        acc = 1;
        for (longint i = 0; i < n2; i++) begin
          p = acc * n1;
          if (p >= MODV) e_ovf = 1;
          acc = p % MODV;
        end
        e_out = acc;
        e_lat = 1 + ((n2 == 0) ? 1 : n2);
      end
    endcase
  endtask

  function automatic logic [3:0] rnd_digit();
    if ($urandom_range(0, 9) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  initial begin
    longint e_out, e_ovf, e_neg, e_dz, e_err, e_lat;
    logic [7:0] ra, rb;
    logic [2:0] rop;
    int r;
    logic saw_done, out_moved;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.out",  64'(out),  64'd0);
    chk("rst.ovf",  64'(ovf),  64'd0);
    chk("rst.neg",  64'(neg),  64'd0);
    chk("rst.dz",   64'(dz),   64'd0);
    chk("rst.err",  64'(err),  64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases, issued back-to-back in the done cycle.
    launch(8'h47, 8'h58, 3'd0); wait_done(0); chk_res("add", 105, 0, 0, 0, 0, 2);
    @(posedge clk); #1;
    chk("hold.done", 64'(done), 64'd0);
    chk("hold.out",  64'(out),  64'd105);
    launch(8'h12, 8'h30, 3'd1); wait_done(0); chk_res("sub", 16366, 0, 1, 0, 0, 2);
    launch(8'h99, 8'h99, 3'd2); wait_done(0); chk_res("mul", 9801, 0, 0, 0, 0, 9);
    launch(8'h97, 8'h00, 3'd3); wait_done(0); chk_res("div0", 16383, 0, 0, 1, 1, 9);
    launch(8'h97, 8'h07, 3'd5); wait_done(0); chk_res("mod", 6, 0, 0, 0, 0, 9);
    launch(8'h09, 8'h05, 3'd4); wait_done(0); chk_res("pow", 9897, 1, 0, 0, 0, 6);
    launch(8'h09, 8'h00, 3'd4); wait_done(0); chk_res("pow0", 1, 0, 0, 0, 0, 2);
    launch(8'h3A, 8'h11, 3'd0); wait_done(0); chk_res("baddig", 0, 0, 0, 0, 1, 1);
    launch(8'h12, 8'h34, 3'd7); wait_done(0); chk_res("badop", 0, 0, 0, 0, 1, 1);

    // A start during EXEC must not disturb the running multiply.
    launch(8'h12, 8'h34, 3'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 8'h99; b = 8'h11; op = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3); chk_res("mul_ignore", 408, 0, 0, 0, 0, 9);
    @(posedge clk); #1;
    chk("ignore.busy", 64'(busy), 64'd0);
    chk("ignore.done", 64'(done), 64'd0);

    // Reset at EXEC cycle 4 aborts the operation.
    launch(8'h25, 8'h37, 3'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 8'h99; b = 8'h11; op = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort.busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    chk("abort.out",  64'(out),  64'd0);
    chk("abort.flags", 64'({ovf, neg, dz, err}), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0; out_moved = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
      if (out != '0) out_moved = 1'b1;
    end
    chk("abort.no_done", 64'(saw_done), 64'd0);
    chk("abort.out_held", 64'(out_moved), 64'd0);

    // Start held across reset release is taken on the first live edge.
    @(negedge clk);
    rst_n = 1'b0; a = 8'h21; b = 8'h34; op = 3'd0; start = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rel.busy", 64'(busy), 64'd1);
    wait_done(0); chk_res("rel_add", 55, 0, 0, 0, 0, 2);

    // Random operations against the reference model.
    for (int it = 0; it < 60; it++) begin
      ra = {rnd_digit(), rnd_digit()};
      rb = {rnd_digit(), rnd_digit()};
      r  = int'($urandom_range(0, 13));
      rop = (r < 12) ? 3'(r % 6) : 3'(r - 6);
      model(ra, rb, rop, e_out, e_ovf, e_neg, e_dz, e_err, e_lat);
      launch(ra, rb, rop);
      wait_done(0);
      chk_res($sformatf("rnd%0d_op%0d", it, rop), e_out, e_ovf, e_neg, e_dz, e_err, e_lat);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk("rnd.pulse", 64'(done), 64'd0);
        chk("rnd.hold",  64'(out),  64'(e_out));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
